// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file: selects the write-back value, commits it,
// and serves two combinational decode read ports with same-cycle WB->ID bypass.
module wb_regfile #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 4,
    parameter int CSIZE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] mem_data_in,
    input  logic [DSIZE-1:0] aluout_in,
    input  logic [ASIZE-1:0] waddr_in,
    input  logic             write_en_in,
    input  logic             mem_to_reg_in,
    input  logic [ASIZE-1:0] raddr1,
    input  logic [ASIZE-1:0] raddr2,
    output logic [DSIZE-1:0] rdata1,
    output logic [DSIZE-1:0] rdata2,
    output logic [DSIZE-1:0] wb_data,
    output logic             wb_commit,
    output logic [CSIZE-1:0] commit_cnt
);

    localparam int NREG = 2 ** ASIZE;

    logic [DSIZE-1:0] regs [NREG];

    assign wb_data = mem_to_reg_in ? mem_data_in : aluout_in;

    // write_en_in gates first so an X address or data with no request cannot commit.
    assign wb_commit = write_en_in & (waddr_in != '0) & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_commit) begin
            regs[waddr_in] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_cnt <= '0;
        end else if (wb_commit) begin
            commit_cnt <= commit_cnt + 1'b1;
        end
    end

    // Each read port resolves independently: zero, then bypass, then stored value.
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (wb_commit && (raddr1 == waddr_in)) rdata1 = wb_data;
        if (wb_commit && (raddr2 == waddr_in)) rdata2 = wb_data;
        if (rst || (raddr1 == '0)) rdata1 = '0;
        if (rst || (raddr2 == '0)) rdata2 = '0;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile, built with a 4-bit commit counter so the wrap is reachable.
module tb_wb_regfile;

    localparam int DSIZE = 16;
    localparam int ASIZE = 4;
    localparam int CSIZE = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [DSIZE-1:0] mem_data_in;
    logic [DSIZE-1:0] aluout_in;
    logic [ASIZE-1:0] waddr_in;
    logic             write_en_in;
    logic             mem_to_reg_in;
    logic [ASIZE-1:0] raddr1;
    logic [ASIZE-1:0] raddr2;
    logic [DSIZE-1:0] rdata1;
    logic [DSIZE-1:0] rdata2;
    logic [DSIZE-1:0] wb_data;
    logic             wb_commit;
    logic [CSIZE-1:0] commit_cnt;

    int checks = 0;
    int errors = 0;
    logic [CSIZE-1:0] exp_cnt;
    logic [DSIZE-1:0] mdl [16];

    wb_regfile #(.DSIZE(DSIZE), .ASIZE(ASIZE), .CSIZE(CSIZE)) dut (
        .clk(clk), .rst(rst),
        .mem_data_in(mem_data_in), .aluout_in(aluout_in),
        .waddr_in(waddr_in), .write_en_in(write_en_in), .mem_to_reg_in(mem_to_reg_in),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .wb_data(wb_data), .wb_commit(wb_commit), .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired, actual running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic we, input logic [ASIZE-1:0] wa, input logic mtr,
                         input logic [DSIZE-1:0] md, input logic [DSIZE-1:0] alu);
        write_en_in   = we;
        waddr_in      = wa;
        mem_to_reg_in = mtr;
        mem_data_in   = md;
        aluout_in     = alu;
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive(1'b1, 4'd9, 1'b0, 16'h0000, 16'h5A5A);
        raddr1 = 4'd9;
        raddr2 = 4'd9;
        @(posedge clk); #1;
        exp_cnt = 4'd1;
        checks++;
        if (rdata1 !== 16'h5A5A) begin
            errors++; $display("FAIL reset_prewrite: actual %h required %h", rdata1, 16'h5A5A);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (rdata1 !== 16'h0 || rdata2 !== 16'h0) begin
            errors++; $display("FAIL reset_rdata: actual %h/%h required 0/0", rdata1, rdata2);
        end
        checks++;
        if (commit_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_cnt: actual %0d required 0", commit_cnt);
        end
        checks++;
        if (wb_commit !== 1'b0) begin
            errors++; $display("FAIL reset_commit: actual %b required 0", wb_commit);
        end
        checks++;
        if (wb_data !== 16'h5A5A) begin
            errors++; $display("FAIL reset_wbdata: actual %h required %h", wb_data, 16'h5A5A);
        end
        write_en_in = 1'b0;
        rst = 1'b0;
        exp_cnt = 4'd0;
        #1;
        checks++;
        if (rdata1 !== 16'h0) begin
            errors++; $display("FAIL reset_cleared: actual %h required 0", rdata1);
        end
    endtask

    task automatic test_alu_wb();
        @(negedge clk);
        drive(1'b1, 4'd3, 1'b0, 16'hDEAD, 16'h1234);
        raddr1 = 4'd3;
        raddr2 = 4'd0;
        #1;
        checks++;
        if (wb_data !== 16'h1234 || wb_commit !== 1'b1) begin
            errors++; $display("FAIL alu_mux: actual %h/%b required 1234/1", wb_data, wb_commit);
        end
        @(posedge clk); #1;
        exp_cnt++;
        @(negedge clk);
        drive(1'b0, 4'd3, 1'b0, 16'h0, 16'h0);
        #1;
        checks++;
        if (rdata1 !== 16'h1234) begin
            errors++; $display("FAIL alu_read: actual %h required 1234", rdata1);
        end
        checks++;
        if (commit_cnt !== exp_cnt) begin
            errors++; $display("FAIL alu_cnt: actual %0d required %0d", commit_cnt, exp_cnt);
        end
    endtask

    task automatic test_load_bypass();
        @(negedge clk);
        drive(1'b1, 4'd5, 1'b1, 16'hBEEF, 16'h7777);
        raddr1 = 4'd3;
        raddr2 = 4'd5;
        #1;
        checks++;
        if (rdata2 !== 16'hBEEF) begin
            errors++; $display("FAIL load_bypass: actual %h required BEEF", rdata2);
        end
        checks++;
        if (rdata1 !== 16'h1234) begin
            errors++; $display("FAIL load_other_port: actual %h required 1234", rdata1);
        end
        @(posedge clk); #1;
        exp_cnt++;
        @(negedge clk);
        drive(1'b0, 4'd0, 1'b0, 16'h0, 16'h0);
        #1;
        checks++;
        if (rdata2 !== 16'hBEEF) begin
            errors++; $display("FAIL load_stored: actual %h required BEEF", rdata2);
        end
        checks++;
        if (commit_cnt !== exp_cnt) begin
            errors++; $display("FAIL load_cnt: actual %0d required %0d", commit_cnt, exp_cnt);
        end
    endtask

    task automatic test_r0_write();
        @(negedge clk);
        drive(1'b1, 4'd0, 1'b0, 16'h0, 16'hFFFF);
        raddr1 = 4'd0;
        #1;
        checks++;
        if (rdata1 !== 16'h0 || wb_commit !== 1'b0) begin
            errors++; $display("FAIL r0_before: actual %h/%b required 0/0", rdata1, wb_commit);
        end
        @(posedge clk); #1;
        checks++;
        if (rdata1 !== 16'h0) begin
            errors++; $display("FAIL r0_after: actual %h required 0", rdata1);
        end
        checks++;
        if (commit_cnt !== exp_cnt) begin
            errors++; $display("FAIL r0_cnt: actual %0d required %0d", commit_cnt, exp_cnt);
        end
    endtask

    task automatic test_dual_bypass();
        @(negedge clk);
        drive(1'b1, 4'd3, 1'b0, 16'h0, 16'h4321);
        raddr1 = 4'd3;
        raddr2 = 4'd3;
        #1;
        checks++;
        if (rdata1 !== 16'h4321 || rdata2 !== 16'h4321) begin
            errors++; $display("FAIL dual_bypass: actual %h/%h required 4321/4321", rdata1, rdata2);
        end
        @(posedge clk); #1;
        exp_cnt++;
    endtask

    task automatic test_x_safety();
        @(negedge clk);
        drive(1'b0, 'x, 1'b0, 'x, 'x);
        raddr1 = 4'd3;
        raddr2 = 4'd5;
        #1;
        checks++;
        if (wb_commit !== 1'b0) begin
            errors++; $display("FAIL x_commit: actual %b required 0", wb_commit);
        end
        @(posedge clk); #1;
        checks++;
        if (rdata1 !== 16'h4321 || rdata2 !== 16'hBEEF) begin
            errors++; $display("FAIL x_regs: actual %h/%h required 4321/BEEF", rdata1, rdata2);
        end
        checks++;
        if (commit_cnt !== exp_cnt) begin
            errors++; $display("FAIL x_cnt: actual %0d required %0d", commit_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        drive(1'b1, 4'd7, 1'b0, 16'h0, 16'h00AA);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 16'h0, 16'h0);
        raddr1 = 4'd7;
        raddr2 = 4'd3;
        exp_cnt = 4'd0;
        #1;
        checks++;
        if (rdata1 !== 16'h0 || rdata2 !== 16'h0) begin
            errors++; $display("FAIL midop_regs: actual %h/%h required 0/0", rdata1, rdata2);
        end
        checks++;
        if (commit_cnt !== exp_cnt) begin
            errors++; $display("FAIL midop_cnt: actual %0d required 0", commit_cnt);
        end
        // First write after release must land on the very next edge.
        drive(1'b1, 4'd7, 1'b0, 16'h0, 16'h00AB);
        @(posedge clk); #1;
        exp_cnt++;
        @(negedge clk);
        drive(1'b0, 4'd0, 1'b0, 16'h0, 16'h0);
        #1;
        checks++;
        if (rdata1 !== 16'h00AB || commit_cnt !== exp_cnt) begin
            errors++; $display("FAIL midop_first: actual %h/%0d required 00AB/%0d", rdata1, commit_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [ASIZE-1:0] a;
        logic [DSIZE-1:0] d;
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        exp_cnt = 4'd0;
        for (int k = 0; k < 16; k++) mdl[k] = 16'h0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            a = 4'((i % 15) + 1);
            d = 16'hA000 + 16'(i);
            if (i % 2 == 1) drive(1'b1, a, 1'b1, d, ~d);
            else            drive(1'b1, a, 1'b0, ~d, d);
            mdl[a] = d;
            @(posedge clk); #1;
            exp_cnt++;
            if (i == 7) begin
                @(negedge clk);
                drive(1'b0, 'x, 1'b1, 'x, 'x);
                @(posedge clk); #1;
                checks++;
                if (commit_cnt !== 4'd8) begin
                    errors++; $display("FAIL b2b_idle_cnt: actual %0d required 8", commit_cnt);
                end
            end
            if (i == 15) begin
                checks++;
                if (commit_cnt !== 4'd0) begin
                    errors++; $display("FAIL b2b_wrap_zero: actual %0d required 0", commit_cnt);
                end
            end
        end
        @(negedge clk);
        drive(1'b0, 4'd0, 1'b0, 16'h0, 16'h0);
        #1;
        checks++;
        if (commit_cnt !== 4'd1 || commit_cnt !== exp_cnt) begin
            errors++; $display("FAIL b2b_wrap_cnt: actual %0d required 1", commit_cnt);
        end
        for (int k = 1; k < 16; k++) begin
            raddr1 = 4'(k);
            raddr2 = 4'(16 - k);
            #1;
            checks++;
            if (rdata1 !== mdl[k] || rdata2 !== mdl[16 - k]) begin
                errors++;
                $display("FAIL b2b_reg%0d: actual %h/%h required %h/%h", k, rdata1, rdata2, mdl[k], mdl[16 - k]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'd0, 1'b0, 16'h0, 16'h0);
        raddr1 = 4'd0;
        raddr2 = 4'd0;
        exp_cnt = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_alu_wb();
        test_load_bypass();
        test_r0_write();
        test_dual_bypass();
        test_x_safety();
        test_reset_midop();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
